// File: rtl/pipe_stage_skid.sv
// Purpose: single pipeline register stage with a one-entry skid buffer carrying PC/instruction pairs.
// Latency: 1 cycle from accept to presentation when the path is clear; sustains one entry per cycle.
// Backpressure: in_ready is registered (not skid full), so upstream sees no combinational path from out_ready.
module pipe_stage_skid #(
    parameter int                 PC_W        = 32,
    parameter int                 INSTR_W     = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = INSTR_W'(32'h0000_0013),
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        pc_in,
    input  logic [INSTR_W-1:0]     instr_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        pc_out,
    output logic [INSTR_W-1:0]     instr_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Main entry drives the outputs; skid entry catches the one entry that
    // arrives while main is stalled.
    logic                 main_vld;
    logic [PC_W-1:0]      main_pc;
    logic [INSTR_W-1:0]   main_instr;
    logic                 skid_vld;
    logic [PC_W-1:0]      skid_pc;
    logic [INSTR_W-1:0]   skid_instr;

    logic                 main_vld_nxt;
    logic [PC_W-1:0]      main_pc_nxt;
    logic [INSTR_W-1:0]   main_instr_nxt;
    logic                 skid_vld_nxt;
    logic [PC_W-1:0]      skid_pc_nxt;
    logic [INSTR_W-1:0]   skid_instr_nxt;

    logic                 accept;
    logic                 issue;

    assign in_ready  = ~skid_vld;
    assign accept    = in_valid & in_ready;
    assign issue     = main_vld & out_ready;

    assign out_valid = main_vld;
    assign pc_out    = main_pc;
    assign instr_out = main_vld ? main_instr : NOP_INSTR;

    // Next-state for both entries; flush drops everything, data regs only move on a load.
    always_comb begin
        main_vld_nxt   = main_vld;
        main_pc_nxt    = main_pc;
        main_instr_nxt = main_instr;
        skid_vld_nxt   = skid_vld;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;

        if (flush) begin
            main_vld_nxt = 1'b0;
            skid_vld_nxt = 1'b0;
        end else if (!main_vld || issue) begin
            if (skid_vld) begin
                // Oldest entry sits in skid: promote it to keep FIFO order.
                main_vld_nxt   = 1'b1;
                main_pc_nxt    = skid_pc;
                main_instr_nxt = skid_instr;
                skid_vld_nxt   = accept;
                if (accept) begin
                    skid_pc_nxt    = pc_in;
                    skid_instr_nxt = instr_in;
                end
            end else begin
                main_vld_nxt = accept;
                if (accept) begin
                    main_pc_nxt    = pc_in;
                    main_instr_nxt = instr_in;
                end
            end
        end else if (accept) begin
            // Main is stalled: park the new entry in skid.
            skid_vld_nxt   = 1'b1;
            skid_pc_nxt    = pc_in;
            skid_instr_nxt = instr_in;
        end
    end

    // Entry registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld   <= 1'b0;
            main_pc    <= '0;
            main_instr <= '0;
            skid_vld   <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            main_vld   <= main_vld_nxt;
            main_pc    <= main_pc_nxt;
            main_instr <= main_instr_nxt;
            skid_vld   <= skid_vld_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
        end
    end

    // Saturating count of cycles where downstream refused a presented entry; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_vld && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Purpose: randomized + directed check of pipe_stage_skid against a queue-based reference model.
// Latency: model treats the stage as a 2-deep FIFO whose head is visible on the outputs.
// Backpressure: upstream source re-presents the same PC until the model sees it accepted.
module tb_pipe_stage_skid;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int SCW     = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc_out;
    logic [INSTR_W-1:0] instr_out;
    logic [SCW-1:0]    stall_cnt;

    pipe_stage_skid #(
        .PC_W        (PC_W),
        .INSTR_W     (INSTR_W),
        .NOP_INSTR   (NOP),
        .STALL_CNT_W (SCW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of at most two entries, head shown at the outputs.
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic [31:0] last_pc;
    int          m_stall;
    bit          acc_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        acc_last = 1'b0;
        if (reset) begin
            q_pc.delete();
            q_instr.delete();
            last_pc = '0;
            m_stall = 0;
        end else begin
            if (q_pc.size() > 0 && !out_ready && m_stall < (1 << SCW) - 1)
                m_stall++;
            if (flush) begin
                q_pc.delete();
                q_instr.delete();
            end else begin
                acc_last = in_valid && (q_pc.size() < 2);
                if (q_pc.size() > 0 && out_ready) begin
                    void'(q_pc.pop_front());
                    void'(q_instr.pop_front());
                end
                if (acc_last) begin
                    q_pc.push_back(pc_in);
                    q_instr.push_back(instr_in);
                end
            end
        end
        if (q_pc.size() > 0) last_pc = q_pc[0];
    endtask

    task automatic check_all();
        logic        e_vld;
        logic [31:0] e_instr;
        e_vld   = (q_pc.size() > 0);
        e_instr = e_vld ? q_instr[0] : NOP;
        chk("out_valid", 64'(out_valid), 64'(e_vld));
        chk("pc_out",    64'(pc_out),    64'(last_pc));
        chk("instr_out", 64'(instr_out), 64'(e_instr));
        chk("in_ready",  64'(in_ready),  64'(q_pc.size() < 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge,
    // then the source advances its PC if the entry was taken.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        if (acc_last) begin
            pc_in    = pc_in + 32'd4;
            instr_in = $urandom;
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        pc_in     = '0;
        instr_in  = $urandom;
        flush     = 1'b0;
        out_ready = 1'b0;
        last_pc   = '0;
        m_stall   = 0;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_instr_nop", 64'(instr_out), 64'(NOP));
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0;

        // Streaming: one entry per cycle, no stalls
        pc_in     = 32'h0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("stream_pc", 64'(pc_out), 64'd44);
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Backpressure: drain, then feed 0x10.. while downstream stalls
        in_valid = 1'b0;
        step();
        pc_in     = 32'h10;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_head_pc",  64'(pc_out),    64'h10);
        chk("bp_in_ready", 64'(in_ready),  64'd0);
        chk("bp_held_pc",  64'(pc_in),     64'h18);
        chk("bp_stall",    64'(stall_cnt), 64'd3);
        out_ready = 1'b1;
        step();
        chk("bp_issue1", 64'(pc_out), 64'h14);
        step();
        chk("bp_issue2", 64'(pc_out), 64'h18);
        for (int i = 0; i < 3; i++) step();

        // Flush with both entries full and an incoming entry
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        flush = 1'b1;
        step();
        flush    = 1'b0;
        pc_in    = pc_in + 32'd4;
        instr_in = $urandom;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_instr_nop", 64'(instr_out), 64'(NOP));
        chk("fl_in_ready",  64'(in_ready),  64'd1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Reset mid-stream with skid full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_pc_zero",   64'(pc_out),    64'd0);
        chk("mr_stall",     64'(stall_cnt), 64'd0);

        // Saturation of the 4-bit stall counter
        in_valid = 1'b1;
        for (int i = 0; i < 21; i++) step();
        chk("sat_stall", 64'(stall_cnt), 64'd15);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_flush_keeps", 64'(stall_cnt), 64'd15);

        // Randomized traffic
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The module SHALL have parameter PC_W, default 32, meaning program-counter width in bits.
REQ-002 The module SHALL have parameter INSTR_W, default 32, meaning instruction width in bits.
REQ-003 The module SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the bubble value driven on instr_out when no valid entry is presented.
REQ-004 The module SHALL have parameter STALL_CNT_W, default 16, meaning stall-counter width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 pc_in  input  PC_W  upstream PC.
REQ-010 instr_in  input  INSTR_W  upstream instruction.
REQ-011 flush  input  1  discard all held and incoming entries.
REQ-012 out_valid  output  1  downstream entry present.
REQ-013 out_ready  input  1  downstream accepts this cycle.
REQ-014 pc_out  output  PC_W  held PC.
REQ-015 instr_out  output  INSTR_W  held instruction, or NOP_INSTR when out_valid=0.
REQ-016 stall_cnt  output  STALL_CNT_W  count of downstream-stall cycles.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid (overflow), each with its own valid bit.
REQ-018 in_ready SHALL equal NOT skid_valid, derived from registered state only, with no combinational path from out_ready or in_valid.
REQ-019 Accept SHALL occur when in_valid=1 and in_ready=1 at a rising edge; issue SHALL occur when out_valid=1 and out_ready=1.
REQ-020 out_valid SHALL equal main_valid; pc_out SHALL equal main PC; instr_out SHALL be main instruction when main_valid=1, else NOP_INSTR.
REQ-021 If main is empty or issuing and skid is valid, main SHALL load from skid and skid SHALL clear (or take the accepted input if one arrives in the same cycle).
REQ-022 If main is empty or issuing and skid is empty, main SHALL load the accepted input, or become invalid if there is no accept.
REQ-023 If main is full and not issuing and an accept occurs, the entry SHALL go to skid.
REQ-024 Latency SHALL be 1 cycle: an entry accepted at edge N is presented at out from edge N when the path is clear; order SHALL be strictly FIFO; no entry SHALL be dropped or duplicated.
REQ-025 Continuous in_valid=1/out_ready=1 SHALL sustain one entry per cycle.
REQ-026 flush=1 at an edge SHALL clear main_valid and skid_valid; any same-cycle accept SHALL be discarded; flush SHALL take priority over accept and issue.
REQ-027 After a flush, in_ready SHALL be 1 in the next cycle.
REQ-028 Data registers SHALL load only on accept, skid promotion or main load, and SHALL otherwise hold.
REQ-029 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, SHALL saturate at 2^STALL_CNT_W-1, and SHALL not be cleared by flush.

Reset
REQ-030 reset=1 at an edge SHALL set main_valid=0, skid_valid=0, pc_out=0, both data registers to zero, and stall_cnt=0; instr_out SHALL read NOP_INSTR.
REQ-031 reset SHALL take priority over flush, accept and issue; in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-032 Streaming: after reset, drive pc_in=0,4,8,... with in_valid=1 and out_ready=1 -> pc_out follows one cycle later with no gaps, in_ready is constantly 1, and stall_cnt stays 0.
REQ-033 Backpressure: out_ready=0 while feeding pc 0x10, 0x14, 0x18 -> out holds 0x10, skid holds 0x14, in_ready=0 and 0x18 is held upstream; stall_cnt=3 after 3 stalled cycles; on out_ready=1 the sequence 0x10, 0x14, 0x18 issues in order.
REQ-034 Flush with both entries full and in_valid=1 -> next cycle out_valid=0, instr_out=0x00000013, in_ready=1, and the flushed-cycle input never appears.
REQ-035 Reset mid-stream with skid full -> all outputs return to reset values in one cycle and stall_cnt=0.
REQ-036 Saturation: with STALL_CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt stops at 15.
